instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 161 ++++++++++++++++
 tb/tb_instr_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Field-bundle to RV32 word encoder for add/sub/and/or, lw, sw and beq.
// Streams {instr, addr} words through a 2-entry FIFO toward an imem write port.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [1:0]  in_funct,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [12:0] in_imm,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        done,
  output logic        err,
  output logic [15:0] words
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [15:0] MaxW = 16'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [63:0] fifo_q [2];
  logic [63:0] fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic        err_q, err_d;

  logic [31:0] instr;
  logic        legal;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic        accept;
  logic        push;
  logic        pop;
  logic [63:0] head;

  always_comb begin
    f7 = 7'b0000000;
    f3 = 3'b000;
    case (in_funct)
      2'b01:   f7 = 7'b0100000;
      2'b10:   f3 = 3'b111;
      2'b11:   f3 = 3'b110;
      default: f3 = 3'b000;
    endcase
  end

  // lw/sw take a 12-bit signed offset; beq needs an even byte offset
  always_comb begin
    instr = '0;
    legal = 1'b1;
    case (in_op)
      2'b00: instr = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
      2'b01: begin
        instr = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
        legal = (in_imm[12] == in_imm[11]);
      end
      2'b10: begin
        instr = {in_imm[11:5], in_rs2, in_rs1, 3'b010,
                 in_imm[4:0], 7'b0100011};
        legal = (in_imm[12] == in_imm[11]);
      end
      default: begin
        instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                 in_imm[4:1], in_imm[11], 7'b1100011};
        legal = ~in_imm[0];
      end
    endcase
  end

  assign in_ready = (state_q == RUN) && (cnt_q < 2'd2) && (words_q < MaxW);
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = (cnt_q != 2'd0) & out_ready;

  always_comb begin
    state_d  = state_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    addr_d   = addr_q;
    words_d  = words_q;
    err_d    = err_q;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {instr, addr_q};
      wr_ptr_d         = ~wr_ptr_q;
      addr_d           = addr_q + 32'd4;
      words_d          = words_q + 16'd1;
    end
    if (accept && !legal) err_d = 1'b1;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          words_d = '0;
          err_d   = 1'b0;
          addr_d  = BASE_ADDR;
        end
      end
      RUN: begin
        if ((accept && in_last) || (push && (words_q + 16'd1 == MaxW)))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = DONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fifo_q   <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      words_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      err_q    <= err_d;
    end
  end

  assign head      = fifo_q[rd_ptr_q];
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = out_valid ? head[63:32] : '0;
  assign out_addr  = out_valid ? head[31:0] : '0;
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign words     = words_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed programs, a per-cycle reference model,
// and a second MAX_WORDS=2 instance for the word-limit path.
module tb_instr_encoder;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start2 = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [1:0]  in_op = '0, in_funct = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        out_ready = 1'b1, out_ready2 = 1'b1;

  logic        in_ready, out_valid, done, err;
  logic [31:0] out_instr, out_addr;
  logic [15:0] words;
  logic        in_ready2, out_valid2, done2, err2;
  logic [31:0] out_instr2, out_addr2;
  logic [15:0] words2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_funct(in_funct),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .done(done), .err(err), .words(words)
  );

  instr_encoder #(.BASE_ADDR(32'h0000_1000), .MAX_WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .in_valid(in_valid), .in_ready(in_ready2),
    .in_op(in_op), .in_funct(in_funct),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_addr(out_addr2),
    .done(done2), .err(err2), .words(words2)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_enc(int op, logic [31:0] fn,
      logic [31:0] rd, logic [31:0] rs1, logic [31:0] rs2, int imm);
    logic [31:0] u, b, f7, f3;
    u  = 32'(imm) & 32'hFFF;
    b  = 32'(imm) & 32'h1FFF;
    f7 = (fn == 1) ? 32 : 0;
    f3 = (fn == 2) ? 7 : (fn == 3) ? 6 : 0;
    case (op)
      0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
              | (rd << 7) | 51;
      1: return (u << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
      2: return ((u >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
              | ((u & 31) << 7) | 35;
      default: return ((b >> 12) << 31) | (((b >> 5) & 63) << 25)
              | (rs2 << 20) | (rs1 << 15) | (((b >> 1) & 15) << 8)
              | (((b >> 11) & 1) << 7) | 99;
    endcase
  endfunction

  function automatic bit m_legal(int op, int imm);
    if (op == 1 || op == 2) return (imm >= -2048) && (imm <= 2047);
    if (op == 3) return (imm % 2) == 0;
    return 1'b1;
  endfunction

  // model: 0 idle, 1 run, 2 drain, 3 done
  logic [63:0] q[$];
  int          mst = 0;
  int          words_m = 0;
  bit          err_m = 0;
  logic [31:0] addr_m = 0;
  bit          rdy_m, acc_m, pop_m, empty_m;
  int          imm_m;
  logic [31:0] got_a[$];
  logic [31:0] g2_a[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mst = 0; words_m = 0; err_m = 0; addr_m = 0;
    end
    rdy_m = (mst == 1) && (q.size() < 2) && (words_m < MAXW);
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_instr", out_instr, q[0][63:32]);
      chk("out_addr", out_addr, q[0][31:0]);
    end else begin
      chk("idle_instr", out_instr, 32'h0);
      chk("idle_addr", out_addr, 32'h0);
    end
    chk("in_ready", 32'(in_ready), 32'(rdy_m));
    chk("done", 32'(done), 32'(mst == 3));
    chk("err", 32'(err), 32'(err_m));
    chk("words", 32'(words), 32'(words_m));
    if (out_valid && out_ready) got_a.push_back(out_addr);
    if (out_valid2 && out_ready2) g2_a.push_back(out_addr2);
    if (rst_n) begin
      empty_m = (q.size() == 0);
      pop_m   = !empty_m && out_ready;
      acc_m   = in_valid && rdy_m;
      if (pop_m) void'(q.pop_front());
      if (acc_m) begin
        imm_m = int'($signed(in_imm));
        if (m_legal(int'(in_op), imm_m)) begin
          q.push_back({m_enc(int'(in_op), 32'(in_funct), 32'(in_rd),
                             32'(in_rs1), 32'(in_rs2), imm_m), addr_m});
          addr_m  = addr_m + 4;
          words_m = words_m + 1;
        end else begin
          err_m = 1;
        end
      end
      case (mst)
        0, 3: if (start) begin
          mst = 1; words_m = 0; err_m = 0; addr_m = 32'h0;
        end
        1: if (acc_m && (in_last || words_m == MAXW)) mst = 2;
        2: if (empty_m) mst = 3;
        default: mst = 0;
      endcase
    end
  end

  task automatic drive(int op, int fn, int rd, int rs1, int rs2, int imm,
                       bit last);
    in_op    = 2'(op);
    in_funct = 2'(fn);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = 13'(imm);
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc();
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready never rose");
    end
  endtask

  task automatic send(int op, int fn, int rd, int rs1, int rs2, int imm,
                      bit last);
    drive(op, fn, rd, rs1, rs2, imm, last);
    wait_acc();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 50 && !done; i++) @(negedge clk);
    chk("wait_done", 32'(done), 32'h1);
    @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_words", 32'(words), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ready", 32'(in_ready), 32'h0);

    pulse_start();
    send(0, 0, 3, 1, 2, 0, 1);
    chk("add", out_instr, 32'h0020_81B3);
    chk("add_addr", out_addr, 32'h0);
    chk("add_words", 32'(words), 32'h1);
    wait_done();

    pulse_start();
    chk("words_clr", 32'(words), 32'h0);
    send(1, 0, 5, 0, 0, 8, 0);
    chk("lw", out_instr, 32'h0080_2283);
    send(2, 0, 0, 2, 6, -4, 0);
    chk("sw", out_instr, 32'hFE61_2E23);
    chk("sw_addr", out_addr, 32'h4);
    send(3, 0, 0, 1, 2, -8, 1);
    chk("beq", out_instr, 32'hFE20_8CE3);
    chk("beq_addr", out_addr, 32'h8);
    wait_done();

    pulse_start();
    send(0, 1, 3, 1, 2, 0, 0);
    chk("sub", out_instr, 32'h4020_81B3);
    start = 1'b1;
    send(0, 2, 3, 1, 2, 0, 0);
    start = 1'b0;
    chk("and", out_instr, 32'h0020_F1B3);
    chk("start_ignored", 32'(words), 32'h2);
    send(0, 3, 3, 1, 2, 0, 1);
    chk("or", out_instr, 32'h0020_E1B3);
    wait_done();

    pulse_start();
    out_ready = 1'b0;
    send(1, 0, 1, 0, 0, 0, 0);
    send(1, 0, 2, 0, 0, 0, 0);
    drive(1, 0, 3, 0, 0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready", 32'(in_ready), 32'h0);
      chk("bp_hold_i", out_instr, 32'h0000_2083);
      chk("bp_hold_a", out_addr, 32'h0);
    end
    @(posedge clk);
    #1;
    n0 = got_a.size();
    out_ready = 1'b1;
    wait_acc();
    wait_done();
    chk("bp_cnt", 32'(got_a.size() - n0), 32'h3);
    if (got_a.size() - n0 == 3) begin
      chk("bp_a0", got_a[n0], 32'h0);
      chk("bp_a1", got_a[n0+1], 32'h4);
      chk("bp_a2", got_a[n0+2], 32'h8);
    end

    pulse_start();
    send(1, 0, 1, 0, 0, 2048, 0);
    chk("ill_lw_err", 32'(err), 32'h1);
    chk("ill_lw_nov", 32'(out_valid), 32'h0);
    send(3, 0, 0, 1, 2, 3, 0);
    chk("ill_beq_nov", 32'(out_valid), 32'h0);
    send(2, 0, 0, 1, 2, -2049, 0);
    chk("ill_sw_nov", 32'(out_valid), 32'h0);
    send(1, 0, 7, 0, 0, -2048, 0);
    chk("lw_min", out_instr, 32'h8000_2383);
    chk("lw_min_addr", out_addr, 32'h0);
    send(1, 0, 7, 0, 0, 2047, 1);
    chk("lw_max", out_instr, 32'h7FF0_2383);
    wait_done();
    chk("err_sticky", 32'(err), 32'h1);

    start2 = 1'b1;
    pulse_start();
    start2 = 1'b0;
    chk("err_clr", 32'(err), 32'h0);
    send(1, 0, 1, 0, 0, 0, 0);
    send(1, 0, 2, 0, 0, 4, 0);
    send(1, 0, 3, 0, 0, 8, 0);
    for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
    chk("max_done", 32'(done2), 32'h1);
    chk("max_words", 32'(words2), 32'h2);
    chk("max_cnt", 32'(g2_a.size()), 32'h2);
    if (g2_a.size() >= 2) begin
      chk("max_a0", g2_a[0], 32'h1000);
      chk("max_a1", g2_a[1], 32'h1004);
    end

    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(1, 0, 4, 0, 0, 0, 0);
    send(1, 0, 5, 0, 0, 0, 0);
    chk("full_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_instr", out_instr, 32'h0);
    chk("ar_words", 32'(words), 32'h0);
    chk("ar_done2", 32'(done2), 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    pulse_start();
    send(0, 0, 3, 1, 2, 0, 1);
    chk("post_rst_addr", out_addr, 32'h0);
    chk("post_rst_i", out_instr, 32'h0020_81B3);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
